// File: rtl/pmp_unit.sv
// pmp_unit: physical memory protection checker with a pmpcfg/pmpaddr CSR file.
// Each request is checked against up to 16 OFF/TOR/NA4/NAPOT regions, and the
// result is returned one cycle later. The first fault is kept in a sticky record.
// Optional feature macro: PMP_NAPOT_EN enables NAPOT regions. When it is
// undefined, writes of A=3 are stored as A=0 (OFF).
module pmp_unit #(
  parameter int PMP_CNT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_we_i,
  input  logic [11:0]       csr_waddr_i,
  input  logic [31:0]       csr_wdata_i,
  input  logic [11:0]       csr_raddr_i,
  output logic [31:0]       csr_rdata_o,
  input  logic [1:0]        prv_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_r_i,
  input  logic              req_w_i,
  input  logic              req_x_i,
  output logic              rsp_valid_o,
  output logic              rsp_fault_o,
  output logic              fault_valid_o,
  output logic [ADDR_W-1:0] fault_addr_o,
  output logic [1:0]        fault_cause_o,
  input  logic              fault_clr_i
);

  // Comparison width: pmpaddr covers byte address bits [33:2], plus headroom
  // so that exclusive region ends and access ends never wrap.
  localparam int XW = ((ADDR_W > 32) ? ADDR_W : 32) + 4;

  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } amode_e;

  // Legalise a written cfg byte: bits 6:5 are hard-wired to zero, and A=3 is
  // folded to OFF when NAPOT support is not built in.
  function automatic logic [7:0] cfg_legal(input logic [7:0] d);
    logic [7:0] o;
    o = {d[7], 2'b00, d[4:0]};
`ifndef PMP_NAPOT_EN
    if (d[4:3] == A_NAPOT) begin
      o[4:3] = A_OFF;
    end else begin
      o[4:3] = d[4:3];
    end
`endif
    return o;
  endfunction

  // Encode the access type as the recorded fault cause.
  function automatic logic [1:0] cause_of(input logic r, input logic w);
    logic [1:0] c;
    if (r) begin
      c = 2'd0;
    end else if (w) begin
      c = 2'd1;
    end else begin
      c = 2'd2;
    end
    return c;
  endfunction

  logic [7:0]        r_cfg     [16];
  logic [31:0]       r_pmpaddr [16];
  logic [15:0]       w_cfg_we;
  logic [15:0]       w_addr_we;
  logic [15:0]       w_en;
  logic [XW-1:0]     w_lo      [16];
  logic [XW-1:0]     w_hi      [16];
  logic [XW-1:0]     w_start;
  logic [XW-1:0]     w_end;
  logic              w_found;
  logic              w_fault;
  logic              w_accept;
  logic              r_rsp_valid;
  logic              r_rsp_fault;
  logic              r_fault_valid;
  logic [ADDR_W-1:0] r_fault_addr;
  logic [1:0]        r_fault_cause;

  // Decode CSR write enables, honouring the entry lock and the TOR lock held
  // by the next entry over this entry's address register.
  always_comb begin
    w_cfg_we  = 16'h0000;
    w_addr_we = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (i < PMP_CNT) begin
        w_cfg_we[i]  = csr_we_i && (csr_waddr_i == (12'h3A0 + 12'(i / 4))) && !r_cfg[i][7];
        w_addr_we[i] = csr_we_i && (csr_waddr_i == (12'h3B0 + 12'(i))) && !r_cfg[i][7] &&
                       !(((i + 1) < PMP_CNT) && r_cfg[(i + 1) % 16][7] &&
                         (r_cfg[(i + 1) % 16][4:3] == A_TOR));
      end else begin
        w_cfg_we[i]  = 1'b0;
        w_addr_we[i] = 1'b0;
      end
    end
  end

  // CSR storage; unimplemented entries are never written and stay zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_cfg[i]     <= 8'h00;
        r_pmpaddr[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_cfg_we[i]) begin
          r_cfg[i] <= cfg_legal(csr_wdata_i[8*(i%4) +: 8]);
        end
        if (w_addr_we[i]) begin
          r_pmpaddr[i] <= csr_wdata_i;
        end
      end
    end
  end

  // Combinational CSR read mux; anything unmapped reads as zero.
  always_comb begin
    csr_rdata_o = 32'h0000_0000;
    if (csr_raddr_i[11:2] == 10'b0011_1010_00) begin
      for (int b = 0; b < 4; b++) begin
        csr_rdata_o[8*b +: 8] = r_cfg[{csr_raddr_i[1:0], 2'(b)}];
      end
    end else if (csr_raddr_i[11:4] == 8'h3B) begin
      csr_rdata_o = r_pmpaddr[csr_raddr_i[3:0]];
    end else begin
      csr_rdata_o = 32'h0000_0000;
    end
  end

  // Per-entry region bounds as a half-open byte range [lo, hi).
  always_comb begin
    for (int i = 0; i < 16; i++) begin
`ifdef PMP_NAPOT_EN
      logic [32:0] v_p;
      logic [32:0] v_base;
      logic [33:0] v_sz;
      v_p    = {1'b0, r_pmpaddr[i]};
      v_base = v_p & (v_p + 33'd1);
      v_sz   = {1'b0, v_p ^ (v_p + 33'd1)} + 34'd1;
`endif
      w_en[i] = 1'b0;
      w_lo[i] = {XW{1'b0}};
      w_hi[i] = {XW{1'b0}};
      if (i < PMP_CNT) begin
        case (r_cfg[i][4:3])
          A_TOR: begin
            if (i == 0) begin
              w_lo[i] = {XW{1'b0}};
            end else begin
              w_lo[i] = XW'({r_pmpaddr[(i + 15) % 16], 2'b00});
            end
            w_hi[i] = XW'({r_pmpaddr[i], 2'b00});
            w_en[i] = (w_lo[i] < w_hi[i]);
          end
          A_NA4: begin
            w_lo[i] = XW'({r_pmpaddr[i], 2'b00});
            w_hi[i] = w_lo[i] + XW'(4);
            w_en[i] = 1'b1;
          end
`ifdef PMP_NAPOT_EN
          A_NAPOT: begin
            w_lo[i] = XW'({v_base, 2'b00});
            w_hi[i] = XW'({(34'(v_base) + v_sz), 2'b00});
            w_en[i] = 1'b1;
          end
`endif
          default: begin
            w_en[i] = 1'b0;
          end
        endcase
      end else begin
        w_en[i] = 1'b0;
      end
    end
  end

  // Priority check: the lowest-indexed overlapping entry decides; partial
  // overlap always faults, no match is allowed only in M-mode.
  always_comb begin
    w_start = XW'(req_addr_i);
    w_end   = w_start + (XW'(1) << req_size_i);
    w_found = 1'b0;
    w_fault = (prv_i != 2'b11);
    for (int i = 0; i < 16; i++) begin
      if (!w_found && w_en[i] && (w_start < w_hi[i]) && (w_end > w_lo[i])) begin
        w_found = 1'b1;
        if ((w_start >= w_lo[i]) && (w_end <= w_hi[i])) begin
          w_fault = !((req_r_i && r_cfg[i][0]) || (req_w_i && r_cfg[i][1]) ||
                      (req_x_i && r_cfg[i][2]) || ((prv_i == 2'b11) && !r_cfg[i][7]));
        end else begin
          w_fault = 1'b1;
        end
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_accept = req_valid_i && !r_fault_valid;

  // Registered response and sticky fault record; a new fault wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_fault   <= 1'b0;
      r_fault_valid <= 1'b0;
      r_fault_addr  <= {ADDR_W{1'b0}};
      r_fault_cause <= 2'd0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_fault <= w_accept && w_fault;
      if (w_accept && w_fault && (!r_fault_valid || fault_clr_i)) begin
        r_fault_valid <= 1'b1;
        r_fault_addr  <= req_addr_i;
        r_fault_cause <= cause_of(req_r_i, req_w_i);
      end else if (fault_clr_i) begin
        r_fault_valid <= 1'b0;
      end
    end
  end

  assign req_ready_o   = !r_fault_valid;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_fault_o   = r_rsp_fault;
  assign fault_valid_o = r_fault_valid;
  assign fault_addr_o  = r_fault_addr;
  assign fault_cause_o = r_fault_cause;

endmodule
